mem_port_router: RTL
====================

// Module: mem_port_router
// PURPOSE
//  Parametrised load/store router between the core datapath and the memory targets. Decodes each
//  core word address into the local scratchpad (stack), the L1 cache, or unmapped space.
//  Scratchpad is a 1-cycle sync RAM. L1 uses a req/ack handshake with a timeout.
//  Stalls the core until each access completes and records bus errors.
//  Replaces the combinational stack/L1 mux in the core top level.
// PARAMETERS
//  N        32       data width
//  AW       15       core word-address width
//  SP_AW    6        scratchpad address width; scratchpad covers word addresses [0, 2**SP_AW)
//  L1_LIMIT 2**AW    exclusive upper bound of the L1 region [2**SP_AW, L1_LIMIT); above this is unmapped
//  TIMEOUT  64       max cycles in L1_WAIT before abort; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk           in   1       single clock, rising edge
//  reset         in   1       synchronous, active-high
//  load_control  in   1       core load request, held stable while stall=1
//  store_control in   1       core store request, held stable while stall=1
//  address       in   AW      core word address
//  wdata         in   N       core store data
//  rdata         out  N       load data, valid in the completion cycle (stall=0)
//  stall         out  1       core must hold PC and request while high
//  l1_req        out  1       L1 request, held until l1_ack
//  l1_we         out  1       1=store, 0=load; valid with l1_req
//  l1_address    out  AW      latched request address
//  l1_wdata      out  N       latched store data
//  l1_ack        in   1       1-cycle completion pulse from L1
//  l1_rdata      in   N       L1 load data, valid with l1_ack
//  err_clear     in   1       clears err_status
//  err_status    out  2       sticky error: [0] unmapped access, [1] L1 timeout
//  err_address   out  AW      address of the first error since last clear
// BEHAVIOUR
//  Reset: state=IDLE; l1_req=0, l1_we=0, l1_address=0, l1_wdata=0, rdata register=0,
//   err_status=0, err_address=0, timeout counter=0. Scratchpad contents are not reset.
//   Reset mid-access drops l1_req at the same edge; a late l1_ack in IDLE is ignored.
//  Request = load_control|store_control. If both are high, it is treated as a store.
//  FSM states: IDLE, SP_RD, L1_WAIT, RESP.
//  IDLE, no request: stall=0.
//  IDLE, scratchpad store: RAM is written at the edge; stall=0; zero added latency.
//  IDLE, scratchpad load: stall=1, go to SP_RD.
//   SP_RD: rdata=RAM output, stall=0, go to IDLE. Load latency is 1 stall cycle.
//  IDLE, L1 access: stall=1. At the edge, latch address, wdata and op; set l1_req=1;
//   clear the counter; go to L1_WAIT.
//  L1_WAIT: stall=1; counter increments each cycle.
//   If l1_ack: capture l1_rdata, drop l1_req, go to RESP.
//   Else if counter==TIMEOUT-1: drop l1_req, set err_status[1], capture rdata=0, go to RESP.
//  RESP: rdata=captured value, stall=0, go to IDLE. Minimum L1 latency is 2 stall cycles
//   (ack in the first L1_WAIT cycle).
//  Unmapped (address >= L1_LIMIT): completes in IDLE with stall=0, rdata=0; the store is dropped.
//   Sets err_status[0].
//  err_address loads only when err_status==0 before the error; a later error does not overwrite it.
//  Simultaneous err_clear and new error: the error wins (bit set, address recorded).
//  rdata outside completion cycles is don't-care; the bench checks it only when the request
//   is a load and stall=0.
//  Region compares are unsigned on the full AW bits. L1_LIMIT=2**AW disables the unmapped region.
// STRUCTURE
//  mem_router_pkg: typedef enum router_state_t {IDLE,SP_RD,L1_WAIT,RESP};
//   typedef enum region_t {REG_SP,REG_L1,REG_NONE}; ERR_UNMAPPED=0, ERR_TIMEOUT=1 bit indices.
//  Sub-module sp_ram #(N,SP_AW): sync write, registered 1-cycle read, no reset.
//  Address decode is a combinational function in the package, returning region_t.
// TESTING
//  1 SP store then load: store 0xDEADBEEF @5 (stall=0), load @5 -> 1 stall cycle, rdata=0xDEADBEEF.
//  2 L1 load @0x100, ack after 3 cycles with 0x12345678 -> stall high 4 cycles, then rdata=0x12345678;
//    l1_req high for exactly 3 cycles; l1_address=0x100.
//  3 L1 store @0x200, no ack (TIMEOUT=8) -> l1_req drops after 8 cycles; err_status=2'b10;
//    err_address=0x200; the stray ack afterwards is ignored.
//  4 L1_LIMIT=4096, load @0x1800 -> stall=0, rdata=0, err_status[0]=1; a following store @0x1801
//    leaves err_address=0x1800; err_clear -> err_status=0.
//  5 Reset asserted in L1_WAIT -> next cycle l1_req=0, stall=0, state IDLE; SP data written
//    before reset still reads back.
//  6 load_control and store_control both high @3 with wdata=7 -> treated as store; a later load
//    @3 returns 7.

Source files
------------

// File: rtl/mem_router_pkg.sv
// Shared types and the address decoder for the core-to-memory load/store router.
package mem_router_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SP_RD   = 2'd1,
        L1_WAIT = 2'd2,
        RESP    = 2'd3
    } router_state_t;

    typedef enum logic [1:0] {
        REG_SP   = 2'd0,
        REG_L1   = 2'd1,
        REG_NONE = 2'd2
    } region_t;

    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_TIMEOUT  = 1;

    // Unsigned compare on the zero-extended word address.
    function automatic region_t decode_region(input logic [63:0] addr,
                                              input int unsigned sp_aw,
                                              input logic [63:0] l1_limit);
        if (addr < (64'd1 << sp_aw))
            return REG_SP;
        else if (addr < l1_limit)
            return REG_L1;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/mem_port_router_sp_ram.sv
// Scratchpad (stack) RAM: synchronous write, registered one-cycle read, contents not reset.
module sp_ram #(
    parameter int N     = 32,
    parameter int SP_AW = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [SP_AW-1:0] addr,
    input  logic [N-1:0]     wdata,
    output logic [N-1:0]     rdata
);

    logic [N-1:0] mem [2**SP_AW];
    logic [N-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_port_router.sv
// Routes core loads/stores to the scratchpad, the L1 handshake port, or flags them as unmapped,
// stalling the core until each access completes.
module mem_port_router
    import mem_router_pkg::*;
#(
    parameter int          N        = 32,
    parameter int          AW       = 15,
    parameter int          SP_AW    = 6,
    parameter logic [63:0] L1_LIMIT = 64'd1 << AW,
    parameter int          TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_control,
    input  logic          store_control,
    input  logic [AW-1:0] address,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata,
    output logic          stall,
    output logic          l1_req,
    output logic          l1_we,
    output logic [AW-1:0] l1_address,
    output logic [N-1:0]  l1_wdata,
    input  logic          l1_ack,
    input  logic [N-1:0]  l1_rdata,
    input  logic          err_clear,
    output logic [1:0]    err_status,
    output logic [AW-1:0] err_address
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    router_state_t state_reg, state_next;
    logic          l1_req_reg, l1_req_next;
    logic          l1_we_reg, l1_we_next;
    logic [AW-1:0] l1_address_reg, l1_address_next;
    logic [N-1:0]  l1_wdata_reg, l1_wdata_next;
    logic [N-1:0]  rdata_reg, rdata_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    err_status_reg, err_status_next;
    logic [AW-1:0] err_address_reg, err_address_next;

    logic          req;
    region_t       region;
    logic          sp_we, sp_re;
    logic [N-1:0]  sp_rdata;
    logic          err_unmapped, err_timeout;

    assign req    = load_control | store_control;
    assign region = decode_region(64'(address), SP_AW, L1_LIMIT);

    sp_ram #(.N(N), .SP_AW(SP_AW)) u_sp_ram (
        .clk   (clk),
        .we    (sp_we),
        .re    (sp_re),
        .addr  (address[SP_AW-1:0]),
        .wdata (wdata),
        .rdata (sp_rdata)
    );

    always_comb begin
        state_next       = state_reg;
        l1_req_next      = l1_req_reg;
        l1_we_next       = l1_we_reg;
        l1_address_next  = l1_address_reg;
        l1_wdata_next    = l1_wdata_reg;
        rdata_next       = rdata_reg;
        cnt_next         = cnt_reg;
        err_status_next  = err_status_reg;
        err_address_next = err_address_reg;
        stall            = 1'b0;
        sp_we            = 1'b0;
        sp_re            = 1'b0;
        err_unmapped     = 1'b0;
        err_timeout      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (req) begin
                    case (region)
                        REG_SP: begin
                            // Stores retire immediately; loads wait for the registered RAM read.
                            if (store_control) begin
                                sp_we = 1'b1;
                            end else begin
                                sp_re      = 1'b1;
                                stall      = 1'b1;
                                state_next = SP_RD;
                            end
                        end
                        REG_L1: begin
                            stall           = 1'b1;
                            l1_req_next     = 1'b1;
                            l1_we_next      = store_control;
                            l1_address_next = address;
                            l1_wdata_next   = wdata;
                            cnt_next        = '0;
                            state_next      = L1_WAIT;
                        end
                        default: err_unmapped = 1'b1;
                    endcase
                end
            end
            SP_RD: state_next = IDLE;
            L1_WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (l1_ack) begin
                    rdata_next  = l1_rdata;
                    l1_req_next = 1'b0;
                    state_next  = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rdata_next  = '0;
                    l1_req_next = 1'b0;
                    err_timeout = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: state_next = IDLE;
        endcase

        // A new error outranks a simultaneous clear and records its address.
        if (err_clear)
            err_status_next = '0;
        if (err_unmapped || err_timeout) begin
            if (err_status_reg == 2'b00 || err_clear)
                err_address_next = err_unmapped ? address : l1_address_reg;
            err_status_next[ERR_UNMAPPED] = err_status_next[ERR_UNMAPPED] | err_unmapped;
            err_status_next[ERR_TIMEOUT]  = err_status_next[ERR_TIMEOUT]  | err_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            l1_req_reg      <= 1'b0;
            l1_we_reg       <= 1'b0;
            l1_address_reg  <= '0;
            l1_wdata_reg    <= '0;
            rdata_reg       <= '0;
            cnt_reg         <= '0;
            err_status_reg  <= '0;
            err_address_reg <= '0;
        end else begin
            state_reg       <= state_next;
            l1_req_reg      <= l1_req_next;
            l1_we_reg       <= l1_we_next;
            l1_address_reg  <= l1_address_next;
            l1_wdata_reg    <= l1_wdata_next;
            rdata_reg       <= rdata_next;
            cnt_reg         <= cnt_next;
            err_status_reg  <= err_status_next;
            err_address_reg <= err_address_next;
        end
    end

    always_comb begin
        unique case (state_reg)
            SP_RD:   rdata = sp_rdata;
            RESP:    rdata = rdata_reg;
            default: rdata = '0;
        endcase
    end

    assign l1_req      = l1_req_reg;
    assign l1_we       = l1_we_reg;
    assign l1_address  = l1_address_reg;
    assign l1_wdata    = l1_wdata_reg;
    assign err_status  = err_status_reg;
    assign err_address = err_address_reg;

endmodule
